// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at dispatch, completes out of order,
// and retires from the head one entry per cycle.
module reorder_buffer #(
    parameter int ROB_ENTRIES = 16,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(ROB_ENTRIES)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              disp_valid,
    input  logic [4:0]        disp_rd,
    input  logic              disp_wen,
    output logic              disp_ready,
    output logic [IDX_W-1:0]  disp_rob_idx,
    input  logic              ex_valid,
    input  logic [IDX_W-1:0]  rob_entry_idx,
    input  logic [DATA_W-1:0] ex_val,
    input  logic              br_mispred,
    input  logic              exception,
    output logic              commit_valid,
    output logic [4:0]        commit_rd,
    output logic              commit_wen,
    output logic [DATA_W-1:0] commit_val,
    output logic              flush,
    output logic              flush_exception,
    output logic [IDX_W:0]    rob_count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(ROB_ENTRIES);

    logic [ROB_ENTRIES-1:0] ent_valid;
    logic [ROB_ENTRIES-1:0] ent_done;
    logic [ROB_ENTRIES-1:0] ent_mispred;
    logic [ROB_ENTRIES-1:0] ent_exc;
    logic [ROB_ENTRIES-1:0] ent_wen;
    logic [4:0]             ent_rd  [ROB_ENTRIES];
    logic [DATA_W-1:0]      ent_val [ROB_ENTRIES];

    logic [IDX_W:0]   head;
    logic [IDX_W:0]   tail;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             head_ready;
    logic             full;
    logic             disp_fire;
    logic             wb_ok;

    assign head_idx  = head[IDX_W-1:0];
    assign tail_idx  = tail[IDX_W-1:0];
    assign rob_count = tail - head;
    assign full      = (rob_count == FULL_CNT);

    // Head decisions come only from registered state; no writeback bypass.
    assign head_ready      = ent_valid[head_idx] && ent_done[head_idx];
    assign flush           = head_ready &&
                             (ent_mispred[head_idx] || ent_exc[head_idx]);
    assign flush_exception = head_ready && ent_exc[head_idx];
    assign commit_valid    = head_ready && !ent_exc[head_idx];
    assign commit_wen      = commit_valid && ent_wen[head_idx];
    assign commit_rd       = commit_valid ? ent_rd[head_idx] : 5'd0;
    assign commit_val      = commit_valid ? ent_val[head_idx] : '0;

    assign disp_ready   = !full && !flush;
    assign disp_rob_idx = tail_idx;
    assign disp_fire    = disp_valid && disp_ready;
    assign wb_ok        = ex_valid && ent_valid[rob_entry_idx] &&
                          !ent_done[rob_entry_idx];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head        <= '0;
            tail        <= '0;
            ent_valid   <= '0;
            ent_done    <= '0;
            ent_mispred <= '0;
            ent_exc     <= '0;
            ent_wen     <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                ent_rd[i]  <= '0;
                ent_val[i] <= '0;
            end
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (wb_ok) begin
                ent_done[rob_entry_idx]    <= 1'b1;
                ent_val[rob_entry_idx]     <= ex_val;
                ent_exc[rob_entry_idx]     <= exception;
                ent_mispred[rob_entry_idx] <= br_mispred && !exception;
            end
            if (commit_valid) begin
                ent_valid[head_idx] <= 1'b0;
                head                <= head + 1'b1;
            end
            if (disp_fire) begin
                ent_valid[tail_idx]   <= 1'b1;
                ent_done[tail_idx]    <= 1'b0;
                ent_mispred[tail_idx] <= 1'b0;
                ent_exc[tail_idx]     <= 1'b0;
                ent_rd[tail_idx]      <= disp_rd;
                ent_wen[tail_idx]     <= disp_wen;
                tail                  <= tail + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, fill, out-of-order completion,
// mispredict/exception flush and a wrapping steady-state stream.
module tb_reorder_buffer;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          disp_valid = 1'b0;
    logic [4:0]    disp_rd = '0;
    logic          disp_wen = 1'b0;
    logic          disp_ready;
    logic [IW-1:0] disp_rob_idx;
    logic          ex_valid = 1'b0;
    logic [IW-1:0] rob_entry_idx = '0;
    logic [DW-1:0] ex_val = '0;
    logic          br_mispred = 1'b0;
    logic          exception = 1'b0;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic          commit_wen;
    logic [DW-1:0] commit_val;
    logic          flush;
    logic          flush_exception;
    logic [IW:0]   rob_count;

    int n_cmp = 0;
    int n_bad = 0;

    reorder_buffer #(.ROB_ENTRIES(N), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_wen(disp_wen),
        .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
        .ex_valid(ex_valid), .rob_entry_idx(rob_entry_idx), .ex_val(ex_val),
        .br_mispred(br_mispred), .exception(exception),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_wen(commit_wen), .commit_val(commit_val),
        .flush(flush), .flush_exception(flush_exception),
        .rob_count(rob_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        ex_valid   = 1'b0;
        br_mispred = 1'b0;
        exception  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic wen);
        disp_valid = 1'b1;
        disp_rd    = rd;
        disp_wen   = wen;
        tick();
        idle();
    endtask

    task automatic wb(input int idx, input logic [DW-1:0] v,
                      input logic mp, input logic ex);
        ex_valid      = 1'b1;
        rob_entry_idx = IW'(idx);
        ex_val        = v;
        br_mispred    = mp;
        exception     = ex;
        tick();
        idle();
    endtask

    int disp_cyc [64];
    int seq_d;
    int seq_c;
    int last_commit;

    initial begin
        // Reset
        nRST = 1'b0;
        tick();
        check("rst_ready", 64'(disp_ready), 1);
        check("rst_count", 64'(rob_count), 0);
        nRST = 1'b1;
        tick();
        check("rst_ready_rel", 64'(disp_ready), 1);
        check("rst_idx", 64'(disp_rob_idx), 0);
        check("rst_commit", 64'(commit_valid), 0);
        check("rst_wen", 64'(commit_wen), 0);
        check("rst_flush", 64'(flush), 0);
        check("rst_fexc", 64'(flush_exception), 0);

        // Fill to 16 with no writeback
        for (int i = 0; i < N; i++) begin
            check("fill_idx", 64'(disp_rob_idx), 64'(i));
            check("fill_ready", 64'(disp_ready), 1);
            dispatch(5'(i + 1), 1'b1);
        end
        check("full_ready", 64'(disp_ready), 0);
        check("full_count", 64'(rob_count), 16);
        dispatch(5'd30, 1'b1);
        check("full_17th_count", 64'(rob_count), 16);
        check("full_17th_ready", 64'(disp_ready), 0);
        nRST = 1'b0;
        #1;
        check("async_rst_count", 64'(rob_count), 0);
        check("async_rst_ready", 64'(disp_ready), 1);
        nRST = 1'b1;
        tick();

        // Out-of-order completion, in-order retirement
        do_reset();
        dispatch(5'd1, 1'b1);
        dispatch(5'd2, 1'b1);
        dispatch(5'd3, 1'b1);
        wb(2, 32'hC, 1'b0, 1'b0);
        check("ooo_hold2", 64'(commit_valid), 0);
        wb(1, 32'hB, 1'b0, 1'b0);
        check("ooo_hold1", 64'(commit_valid), 0);
        wb(0, 32'hA, 1'b0, 1'b0);
        check("ooo_c0_v", 64'(commit_valid), 1);
        check("ooo_c0_rd", 64'(commit_rd), 1);
        check("ooo_c0_val", 64'(commit_val), 32'hA);
        check("ooo_c0_wen", 64'(commit_wen), 1);
        tick();
        check("ooo_c1_rd", 64'(commit_rd), 2);
        check("ooo_c1_val", 64'(commit_val), 32'hB);
        tick();
        check("ooo_c2_rd", 64'(commit_rd), 3);
        check("ooo_c2_val", 64'(commit_val), 32'hC);
        tick();
        check("ooo_done_v", 64'(commit_valid), 0);
        check("ooo_done_cnt", 64'(rob_count), 0);

        // Mispredict flush
        do_reset();
        for (int i = 0; i < 4; i++) dispatch(5'(4 + i), 1'b1);
        wb(0, 32'h5, 1'b0, 1'b0);
        check("mp_c0_v", 64'(commit_valid), 1);
        check("mp_c0_val", 64'(commit_val), 5);
        check("mp_c0_flush", 64'(flush), 0);
        wb(1, 32'h40, 1'b1, 1'b0);
        check("mp_c1_v", 64'(commit_valid), 1);
        check("mp_c1_rd", 64'(commit_rd), 5);
        check("mp_c1_val", 64'(commit_val), 32'h40);
        check("mp_flush", 64'(flush), 1);
        check("mp_fexc", 64'(flush_exception), 0);
        check("mp_ready", 64'(disp_ready), 0);
        tick();
        check("mp_after_cnt", 64'(rob_count), 0);
        check("mp_after_idx", 64'(disp_rob_idx), 0);
        check("mp_after_ready", 64'(disp_ready), 1);
        wb(2, 32'h7, 1'b0, 1'b0);
        check("mp_stale_wb", 64'(commit_valid), 0);
        check("mp_stale_cnt", 64'(rob_count), 0);

        // Exception flush, then exception beats mispredict
        do_reset();
        dispatch(5'd8, 1'b1);
        dispatch(5'd9, 1'b1);
        wb(0, 32'h11, 1'b0, 1'b1);
        check("exc_commit", 64'(commit_valid), 0);
        check("exc_wen", 64'(commit_wen), 0);
        check("exc_flush", 64'(flush), 1);
        check("exc_fexc", 64'(flush_exception), 1);
        check("exc_cnt", 64'(rob_count), 2);
        tick();
        check("exc_after_cnt", 64'(rob_count), 0);
        check("exc_after_flush", 64'(flush), 0);
        dispatch(5'd10, 1'b1);
        wb(0, 32'h22, 1'b1, 1'b1);
        check("both_fexc", 64'(flush_exception), 1);
        check("both_commit", 64'(commit_valid), 0);
        tick();

        // Full ROB: commit cycle does not free a slot for same-cycle dispatch
        do_reset();
        for (int i = 0; i < N; i++) dispatch(5'(i + 1), 1'b1);
        wb(0, 32'h99, 1'b0, 1'b0);
        check("fc_ready", 64'(disp_ready), 0);
        check("fc_commit", 64'(commit_valid), 1);
        check("fc_cnt", 64'(rob_count), 16);
        disp_valid = 1'b1;
        disp_rd    = 5'd20;
        disp_wen   = 1'b1;
        tick();
        check("fc_cnt2", 64'(rob_count), 15);
        check("fc_ready2", 64'(disp_ready), 1);
        check("fc_idx2", 64'(disp_rob_idx), 0);
        tick();
        idle();
        check("fc_cnt3", 64'(rob_count), 16);
        check("fc_ready3", 64'(disp_ready), 0);

        // Steady stream of 40, writeback two cycles after dispatch
        do_reset();
        seq_d = 0;
        seq_c = 0;
        last_commit = -1;
        for (int cyc = 0; cyc < 200 && seq_c < 40; cyc++) begin
            idle();
            if (commit_valid) begin
                check("st_rd", 64'(commit_rd), 64'(seq_c % 31 + 1));
                check("st_val", 64'(commit_val), 64'(seq_c * 3 + 1));
                seq_c++;
                last_commit = cyc;
            end
            if (seq_d < 40) begin
                check("st_idx", 64'(disp_rob_idx), 64'(seq_d % N));
                disp_valid = 1'b1;
                disp_rd    = 5'(seq_d % 31 + 1);
                disp_wen   = 1'b1;
                disp_cyc[seq_d] = cyc;
                seq_d++;
            end
            if (cyc >= 2 && cyc - 2 < 40 && disp_cyc[cyc - 2] == cyc - 2) begin
                ex_valid      = 1'b1;
                rob_entry_idx = IW'((cyc - 2) % N);
                ex_val        = DW'((cyc - 2) * 3 + 1);
            end
            tick();
        end
        idle();
        check("st_commits", 64'(seq_c), 40);
        check("st_last_cyc", 64'(last_commit), 42);
        check("st_end_cnt", 64'(rob_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
